// File: rtl/serial_subtractor_pkg.sv
// rtl/serial_subtractor_pkg.sv - shared FSM state encodings for the serial arithmetic blocks
package serial_subtractor_pkg;

  // Two-state sequencer shared by the serial adder/subtractor/multiplier family
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/serial_subtractor_fs.sv
// rtl/serial_subtractor_fs.sv - one-bit full subtractor cell, mirror of the full-adder cell
module serial_subtractor_fs (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  // Difference bit and borrow-out for a - b - bin
  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial unsigned subtractor, LSB first, one bit per clock
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] d_sh;
  logic [WIDTH-1:0] d_next;
  logic             bor;
  logic [CNT_W-1:0] cnt;
  logic             d;
  logic             bo;

  // Single shared cell; operands always presented from the LSB of the shifters
  serial_subtractor_fs u_fs (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .bin  (bor),
    .d    (d),
    .bout (bo)
  );

  // Result shifter view with the current bit inserted at the MSB; a one-bit
  // datapath has nothing to shift down, so it degenerates to the bit itself
  generate
    if (WIDTH == 1) begin : g_narrow
      assign d_next = d;
    end else begin : g_wide
      assign d_next = {d, d_sh[WIDTH-1:1]};
    end
  endgenerate

  assign busy = (state == ST_SHIFT);

  // Sequencer: capture operands on start, shift WIDTH bits, then publish result
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      done   <= 1'b0;
      diff   <= '0;
      borrow <= 1'b0;
      a_sh   <= '0;
      b_sh   <= '0;
      d_sh   <= '0;
      bor    <= 1'b0;
      cnt    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_sh  <= a;
            b_sh  <= b;
            bor   <= 1'b0;
            cnt   <= '0;
            state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          d_sh <= d_next;
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          bor  <= bo;
          cnt  <= cnt + 1'b1;
          if (cnt == LAST_BIT) begin
            diff   <= d_next;
            borrow <= bo;
            done   <= 1'b1;
            state  <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - scoreboard bench for serial_subtractor with a reference model
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [3:0] a = '0;
  logic [3:0] b = '0;
  logic       busy, done, borrow;
  logic [3:0] diff;

  logic       start1 = 1'b0;
  logic [0:0] a1 = '0;
  logic [0:0] b1 = '0;
  logic       busy1, done1, borrow1;
  logic [0:0] diff1;

  int n_checks = 0;
  int n_fail   = 0;

  int exp_a[$];
  int exp_b[$];

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(4)) u_dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .diff(diff), .borrow(borrow)
  );

  serial_subtractor #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1),
    .busy(busy1), .done(done1), .diff(diff1), .borrow(borrow1)
  );

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every done must match the oldest outstanding request
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (exp_a.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        int ea, eb, ed, ebor;
        ea = exp_a.pop_front();
        eb = exp_b.pop_front();
        ed = (ea - eb + 16) % 16;
        ebor = (ea < eb) ? 1 : 0;
        check("diff", int'(diff), ed);
        check("borrow", int'(borrow), ebor);
        check("diff_plus_b", int'(diff) + eb, ea + 16 * int'(borrow));
      end
    end
  end

  // Issue one request, scrambling a/b while busy; returns negedges until done
  task automatic run_op(input int ia, input int ib, output int lat, output int busy_cnt);
    int guard;
    guard = 0;
    while (busy !== 1'b0 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    a = 4'(ia);
    b = 4'(ib);
    start = 1'b1;
    exp_a.push_back(ia);
    exp_b.push_back(ib);
    @(posedge clk);
    #1 start = 1'b0;
    lat = 0;
    busy_cnt = 0;
    while (lat < 20) begin
      @(negedge clk);
      lat++;
      if (busy === 1'b1) busy_cnt++;
      if (done === 1'b1) break;
      a = 4'($urandom);
      b = 4'($urandom);
    end
    if (done !== 1'b1) check("done_timeout", 0, 1);
  endtask

  initial begin
    int lat, bc, guard;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_diff", int'(diff), 0);
    check("rst_borrow", int'(borrow), 0);
    check("rst_busy1", int'(busy1), 0);
    rst = 1'b0;
    @(negedge clk);

    // Basic 9-4 with latency
    run_op(9, 4, lat, bc);
    check("basic_latency", lat, 5);
    check("basic_busy_cycles", bc, 4);

    // Wrap-around
    run_op(3, 7, lat, bc);
    run_op(0, 15, lat, bc);

    // Back-to-back: start issued in the done cycle
    run_op(15, 15, lat, bc);
    check("b2b_latency", lat, 5);

    // Exhaustive
    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 16; j++)
        run_op(i, j, lat, bc);

    // Randomized with random idle gaps
    for (int k = 0; k < 40; k++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      run_op(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), lat, bc);
    end

    // Start while busy is ignored
    @(negedge clk);
    a = 4'd10; b = 4'd3; start = 1'b1;
    exp_a.push_back(10);
    exp_b.push_back(3);
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    #1 start = 1'b1; a = 4'd1; b = 4'd2;
    @(posedge clk);
    #1 start = 1'b0;
    guard = 0;
    while (done !== 1'b1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check("ignored_start_done_seen", int'(done), 1);
    repeat (8) @(negedge clk);
    check("ignored_start_queue_empty", exp_a.size(), 0);

    // Reset mid-operation on 12-5: no done, outputs cleared
    @(negedge clk);
    a = 4'd12; b = 4'd5; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("abort_busy", int'(busy), 0);
    check("abort_diff", int'(diff), 0);
    check("abort_borrow", int'(borrow), 0);
    repeat (8) @(negedge clk);
    check("abort_queue_empty", exp_a.size(), 0);

    // WIDTH=1: 0-1
    a1 = 1'b0; b1 = 1'b1; start1 = 1'b1;
    @(posedge clk);
    #1 start1 = 1'b0;
    @(negedge clk);
    check("w1_busy", int'(busy1), 1);
    check("w1_done_early", int'(done1), 0);
    @(negedge clk);
    check("w1_done", int'(done1), 1);
    check("w1_diff", int'(diff1), 1);
    check("w1_borrow", int'(borrow1), 1);
    @(negedge clk);
    check("w1_done_pulse", int'(done1), 0);

    check("final_queue_empty", exp_a.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
